// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR file interface.
// Accepts one CSR-class instruction (csrrw/s/c[i], ecall, mret), reads the CSR,
// issues a single write-back strobe, then returns the old value or a PC redirect.
module csr_access_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_ecall,
    input  logic                  in_is_mret,
    input  logic [ADDR_WIDTH-1:0] in_csr_addr,
    input  logic [4:0]            in_rs1_idx,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [4:0]            in_rd,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [ADDR_WIDTH-1:0] csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_valid,
    output logic                  csr_wen,
    output logic [ADDR_WIDTH-1:0] csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_is_ecall,
    output logic [DATA_WIDTH-1:0] csr_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic                  out_rd_wen,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_redirect_pc,
    output logic                  out_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MTVEC_ADDR = ADDR_WIDTH'(12'h305);
    localparam logic [ADDR_WIDTH-1:0] MEPC_ADDR  = ADDR_WIDTH'(12'h341);

    state_t                  state_q, state_d;
    logic [2:0]              req_funct3_q, req_funct3_d;
    logic                    req_is_ecall_q, req_is_ecall_d;
    logic                    req_is_mret_q, req_is_mret_d;
    logic [ADDR_WIDTH-1:0]   req_csr_addr_q, req_csr_addr_d;
    logic [4:0]              req_rs1_idx_q, req_rs1_idx_d;
    logic [DATA_WIDTH-1:0]   req_rs1_data_q, req_rs1_data_d;
    logic [4:0]              req_rd_q, req_rd_d;
    logic [DATA_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0]   old_val_q, old_val_d;

    logic [ADDR_WIDTH-1:0]   csr_raddr_q, csr_raddr_d;
    logic                    csr_valid_q, csr_valid_d;
    logic                    csr_wen_q, csr_wen_d;
    logic [ADDR_WIDTH-1:0]   csr_waddr_q, csr_waddr_d;
    logic [DATA_WIDTH-1:0]   csr_wdata_q, csr_wdata_d;
    logic                    csr_is_ecall_q, csr_is_ecall_d;
    logic [DATA_WIDTH-1:0]   csr_pc_q, csr_pc_d;
    logic                    out_valid_q, out_valid_d;
    logic [4:0]              out_rd_q, out_rd_d;
    logic [DATA_WIDTH-1:0]   out_rd_data_q, out_rd_data_d;
    logic                    out_rd_wen_q, out_rd_wen_d;
    logic                    out_redirect_q, out_redirect_d;
    logic [DATA_WIDTH-1:0]   out_redirect_pc_q, out_redirect_pc_d;
    logic                    out_illegal_q, out_illegal_d;

    logic [ADDR_WIDTH-1:0]   in_raddr;
    logic                    req_ecall;
    logic                    req_mret;
    logic                    req_illegal;
    logic                    req_csr_op;
    logic                    req_wen;
    logic [DATA_WIDTH-1:0]   req_src;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // Decode the latched request; ecall+mret together or funct3 x00 is illegal.
    assign req_ecall   = req_is_ecall_q & ~req_is_mret_q;
    assign req_mret    = req_is_mret_q & ~req_is_ecall_q;
    assign req_illegal = (req_is_ecall_q & req_is_mret_q) |
                         (~req_is_ecall_q & ~req_is_mret_q & (req_funct3_q[1:0] == 2'b00));
    assign req_csr_op  = ~req_is_ecall_q & ~req_is_mret_q & ~req_illegal;
    assign req_src     = req_funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, req_rs1_idx_q} : req_rs1_data_q;
    assign req_wen     = req_csr_op & ((req_funct3_q[1:0] == 2'b01) | (req_rs1_idx_q != 5'd0));

    // Pick the CSR to read: traps read their vector CSR instead of the encoded address.
    always_comb begin
        in_raddr = in_csr_addr;
        if (in_is_ecall) begin
            in_raddr = MTVEC_ADDR;
        end else if (in_is_mret) begin
            in_raddr = MEPC_ADDR;
        end
    end

    // Write value from the CSR read in flight: RW replaces, RS sets bits, RC clears bits.
    always_comb begin
        req_wdata = '0;
        case (req_funct3_q[1:0])
            2'b01:   req_wdata = req_src;
            2'b10:   req_wdata = csr_rdata | req_src;
            2'b11:   req_wdata = csr_rdata & ~req_src;
            default: req_wdata = '0;
        endcase
    end

    // Next-state and next-output logic; every output is registered and zero outside its state.
    always_comb begin
        state_d           = state_q;
        req_funct3_d      = req_funct3_q;
        req_is_ecall_d    = req_is_ecall_q;
        req_is_mret_d     = req_is_mret_q;
        req_csr_addr_d    = req_csr_addr_q;
        req_rs1_idx_d     = req_rs1_idx_q;
        req_rs1_data_d    = req_rs1_data_q;
        req_rd_d          = req_rd_q;
        req_pc_d          = req_pc_q;
        old_val_d         = old_val_q;
        csr_raddr_d       = csr_raddr_q;
        csr_valid_d       = csr_valid_q;
        csr_wen_d         = csr_wen_q;
        csr_waddr_d       = csr_waddr_q;
        csr_wdata_d       = csr_wdata_q;
        csr_is_ecall_d    = csr_is_ecall_q;
        csr_pc_d          = csr_pc_q;
        out_valid_d       = out_valid_q;
        out_rd_d          = out_rd_q;
        out_rd_data_d     = out_rd_data_q;
        out_rd_wen_d      = out_rd_wen_q;
        out_redirect_d    = out_redirect_q;
        out_redirect_pc_d = out_redirect_pc_q;
        out_illegal_d     = out_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    req_funct3_d   = in_funct3;
                    req_is_ecall_d = in_is_ecall;
                    req_is_mret_d  = in_is_mret;
                    req_csr_addr_d = in_csr_addr;
                    req_rs1_idx_d  = in_rs1_idx;
                    req_rs1_data_d = in_rs1_data;
                    req_rd_d       = in_rd;
                    req_pc_d       = in_pc;
                    csr_raddr_d    = in_raddr;
                    state_d        = S_READ;
                end
            end
            S_READ: begin
                old_val_d      = csr_rdata;
                csr_raddr_d    = '0;
                csr_valid_d    = 1'b1;
                csr_wen_d      = req_wen;
                csr_waddr_d    = req_wen ? req_csr_addr_q : '0;
                csr_wdata_d    = req_wen ? req_wdata : '0;
                csr_is_ecall_d = req_ecall;
                csr_pc_d       = req_ecall ? req_pc_q : '0;
                state_d        = S_WRITE;
            end
            S_WRITE: begin
                csr_valid_d       = 1'b0;
                csr_wen_d         = 1'b0;
                csr_waddr_d       = '0;
                csr_wdata_d       = '0;
                csr_is_ecall_d    = 1'b0;
                csr_pc_d          = '0;
                out_valid_d       = 1'b1;
                out_rd_d          = req_rd_q;
                out_rd_data_d     = old_val_q;
                out_rd_wen_d      = req_csr_op & (req_rd_q != 5'd0);
                out_redirect_d    = req_ecall | req_mret;
                out_redirect_pc_d = (req_ecall | req_mret) ? old_val_q : '0;
                out_illegal_d     = req_illegal;
                state_d           = S_RESP;
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d       = 1'b0;
                    out_rd_d          = '0;
                    out_rd_data_d     = '0;
                    out_rd_wen_d      = 1'b0;
                    out_redirect_d    = 1'b0;
                    out_redirect_pc_d = '0;
                    out_illegal_d     = 1'b0;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request and output registers; reset aborts any operation and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            req_funct3_q      <= '0;
            req_is_ecall_q    <= 1'b0;
            req_is_mret_q     <= 1'b0;
            req_csr_addr_q    <= '0;
            req_rs1_idx_q     <= '0;
            req_rs1_data_q    <= '0;
            req_rd_q          <= '0;
            req_pc_q          <= '0;
            old_val_q         <= '0;
            csr_raddr_q       <= '0;
            csr_valid_q       <= 1'b0;
            csr_wen_q         <= 1'b0;
            csr_waddr_q       <= '0;
            csr_wdata_q       <= '0;
            csr_is_ecall_q    <= 1'b0;
            csr_pc_q          <= '0;
            out_valid_q       <= 1'b0;
            out_rd_q          <= '0;
            out_rd_data_q     <= '0;
            out_rd_wen_q      <= 1'b0;
            out_redirect_q    <= 1'b0;
            out_redirect_pc_q <= '0;
            out_illegal_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_funct3_q      <= req_funct3_d;
            req_is_ecall_q    <= req_is_ecall_d;
            req_is_mret_q     <= req_is_mret_d;
            req_csr_addr_q    <= req_csr_addr_d;
            req_rs1_idx_q     <= req_rs1_idx_d;
            req_rs1_data_q    <= req_rs1_data_d;
            req_rd_q          <= req_rd_d;
            req_pc_q          <= req_pc_d;
            old_val_q         <= old_val_d;
            csr_raddr_q       <= csr_raddr_d;
            csr_valid_q       <= csr_valid_d;
            csr_wen_q         <= csr_wen_d;
            csr_waddr_q       <= csr_waddr_d;
            csr_wdata_q       <= csr_wdata_d;
            csr_is_ecall_q    <= csr_is_ecall_d;
            csr_pc_q          <= csr_pc_d;
            out_valid_q       <= out_valid_d;
            out_rd_q          <= out_rd_d;
            out_rd_data_q     <= out_rd_data_d;
            out_rd_wen_q      <= out_rd_wen_d;
            out_redirect_q    <= out_redirect_d;
            out_redirect_pc_q <= out_redirect_pc_d;
            out_illegal_q     <= out_illegal_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign csr_raddr       = csr_raddr_q;
    assign csr_valid       = csr_valid_q;
    assign csr_wen         = csr_wen_q;
    assign csr_waddr       = csr_waddr_q;
    assign csr_wdata       = csr_wdata_q;
    assign csr_is_ecall    = csr_is_ecall_q;
    assign csr_pc          = csr_pc_q;
    assign out_valid       = out_valid_q;
    assign out_rd          = out_rd_q;
    assign out_rd_data     = out_rd_data_q;
    assign out_rd_wen      = out_rd_wen_q;
    assign out_redirect    = out_redirect_q;
    assign out_redirect_pc = out_redirect_pc_q;
    assign out_illegal     = out_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed bench for csr_access_unit with a one-entry CSR file model.
module tb_csr_access_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_is_ecall;
    logic        in_is_mret;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1_idx;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_valid;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_is_ecall;
    logic [31:0] csr_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_data;
    logic        out_rd_wen;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;
    logic        out_illegal;

    int tests_run;
    int tests_failed;

    // The CSR file returns the modelled value only when the expected address is read.
    logic [11:0] model_addr;
    logic [31:0] model_val;
    assign csr_rdata = (csr_raddr == model_addr) ? model_val : 32'hDEAD_BEEF;

    csr_access_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .in_csr_addr(in_csr_addr),
        .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data), .in_rd(in_rd), .in_pc(in_pc),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_valid(csr_valid), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_is_ecall(csr_is_ecall), .csr_pc(csr_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_rd_data(out_rd_data),
        .out_rd_wen(out_rd_wen), .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
        .out_illegal(out_illegal)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns #1 after the handshake edge (READ state).
    task automatic issue(input logic [2:0] f3, input logic ec, input logic mr, input logic [11:0] addr,
                         input logic [4:0] rs1, input logic [31:0] rs1d, input logic [4:0] rd,
                         input logic [31:0] pc);
        in_funct3   = f3;
        in_is_ecall = ec;
        in_is_mret  = mr;
        in_csr_addr = addr;
        in_rs1_idx  = rs1;
        in_rs1_data = rs1d;
        in_rd       = rd;
        in_pc       = pc;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
        in_funct3   = '0;
        in_is_ecall = 1'b0;
        in_is_mret  = 1'b0;
        in_csr_addr = '0;
        in_rs1_idx  = '0;
        in_rs1_data = '0;
        in_rd       = '0;
        in_pc       = '0;
    endtask

    // Accept the response for one cycle.
    task automatic release_resp();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (csr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_csr_valid: got %b expected 0", csr_valid); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (csr_raddr !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_raddr: got %h expected 000", csr_raddr); end
    endtask

    task automatic test_csrrw();
        model_addr = 12'h300;
        model_val  = 32'h0000_1800;
        issue(3'b001, 1'b0, 1'b0, 12'h300, 5'd1, 32'h8, 5'd5, 32'h8000_0000);
        tests_run++; if (csr_raddr !== 12'h300) begin tests_failed++; $display("[TB] FAIL rw_raddr: got %h expected 300", csr_raddr); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_busy: got %b expected 0", in_ready); end
        tests_run++; if (csr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_early_valid: got %b expected 0", csr_valid); end
        step();
        tests_run++; if (csr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_csr_valid: got %b expected 1", csr_valid); end
        tests_run++; if (csr_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_wen: got %b expected 1", csr_wen); end
        tests_run++; if (csr_waddr !== 12'h300) begin tests_failed++; $display("[TB] FAIL rw_waddr: got %h expected 300", csr_waddr); end
        tests_run++; if (csr_wdata !== 32'h8) begin tests_failed++; $display("[TB] FAIL rw_wdata: got %h expected 00000008", csr_wdata); end
        tests_run++; if (csr_is_ecall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_is_ecall: got %b expected 0", csr_is_ecall); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_early_out: got %b expected 0", out_valid); end
        step();
        tests_run++; if (csr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_valid_pulse: got %b expected 0", csr_valid); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_out_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_rd !== 5'd5) begin tests_failed++; $display("[TB] FAIL rw_out_rd: got %0d expected 5", out_rd); end
        tests_run++; if (out_rd_data !== 32'h1800) begin tests_failed++; $display("[TB] FAIL rw_rd_data: got %h expected 00001800", out_rd_data); end
        tests_run++; if (out_rd_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_rd_wen: got %b expected 1", out_rd_wen); end
        tests_run++; if (out_redirect !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_redirect: got %b expected 0", out_redirect); end
        tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_illegal: got %b expected 0", out_illegal); end
        release_resp();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_out_drop: got %b expected 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rw_ready_back: got %b expected 1", in_ready); end
    endtask

    task automatic test_csrrs_zero();
        model_addr = 12'h305;
        model_val  = 32'h8000_0100;
        issue(3'b010, 1'b0, 1'b0, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h0);
        step();
        tests_run++; if (csr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rs0_csr_valid: got %b expected 1", csr_valid); end
        tests_run++; if (csr_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL rs0_wen: got %b expected 0", csr_wen); end
        tests_run++; if (csr_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rs0_wdata: got %h expected 00000000", csr_wdata); end
        step();
        tests_run++; if (out_rd_data !== 32'h8000_0100) begin tests_failed++; $display("[TB] FAIL rs0_rd_data: got %h expected 80000100", out_rd_data); end
        tests_run++; if (out_rd_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL rs0_rd_wen: got %b expected 1", out_rd_wen); end
        release_resp();
    endtask

    task automatic test_csrrci();
        model_addr = 12'h341;
        model_val  = 32'h0000_000F;
        issue(3'b111, 1'b0, 1'b0, 12'h341, 5'd3, 32'hFFFF_FFFF, 5'd0, 32'h0);
        step();
        tests_run++; if (csr_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL rci_wen: got %b expected 1", csr_wen); end
        tests_run++; if (csr_wdata !== 32'hC) begin tests_failed++; $display("[TB] FAIL rci_wdata: got %h expected 0000000c", csr_wdata); end
        step();
        tests_run++; if (out_rd_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL rci_rd_wen: got %b expected 0", out_rd_wen); end
        tests_run++; if (out_rd_data !== 32'hF) begin tests_failed++; $display("[TB] FAIL rci_rd_data: got %h expected 0000000f", out_rd_data); end
        release_resp();
    endtask

    task automatic test_ecall();
        model_addr = 12'h305;
        model_val  = 32'h8000_0200;
        issue(3'b000, 1'b1, 1'b0, 12'h123, 5'd0, 32'h0, 5'd0, 32'h8000_0010);
        tests_run++; if (csr_raddr !== 12'h305) begin tests_failed++; $display("[TB] FAIL ecall_raddr: got %h expected 305", csr_raddr); end
        step();
        tests_run++; if (csr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ecall_valid: got %b expected 1", csr_valid); end
        tests_run++; if (csr_is_ecall !== 1'b1) begin tests_failed++; $display("[TB] FAIL ecall_strobe: got %b expected 1", csr_is_ecall); end
        tests_run++; if (csr_pc !== 32'h8000_0010) begin tests_failed++; $display("[TB] FAIL ecall_pc: got %h expected 80000010", csr_pc); end
        tests_run++; if (csr_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL ecall_wen: got %b expected 0", csr_wen); end
        step();
        tests_run++; if (out_redirect !== 1'b1) begin tests_failed++; $display("[TB] FAIL ecall_redirect: got %b expected 1", out_redirect); end
        tests_run++; if (out_redirect_pc !== 32'h8000_0200) begin tests_failed++; $display("[TB] FAIL ecall_redir_pc: got %h expected 80000200", out_redirect_pc); end
        tests_run++; if (out_rd_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL ecall_rd_wen: got %b expected 0", out_rd_wen); end
        tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL ecall_illegal: got %b expected 0", out_illegal); end
        release_resp();
    endtask

    task automatic test_mret();
        model_addr = 12'h341;
        model_val  = 32'h8000_0014;
        issue(3'b000, 1'b0, 1'b1, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0050);
        tests_run++; if (csr_raddr !== 12'h341) begin tests_failed++; $display("[TB] FAIL mret_raddr: got %h expected 341", csr_raddr); end
        step();
        tests_run++; if (csr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mret_valid: got %b expected 1", csr_valid); end
        tests_run++; if (csr_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL mret_wen: got %b expected 0", csr_wen); end
        tests_run++; if (csr_is_ecall !== 1'b0) begin tests_failed++; $display("[TB] FAIL mret_is_ecall: got %b expected 0", csr_is_ecall); end
        tests_run++; if (csr_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL mret_pc: got %h expected 00000000", csr_pc); end
        step();
        tests_run++; if (out_redirect !== 1'b1) begin tests_failed++; $display("[TB] FAIL mret_redirect: got %b expected 1", out_redirect); end
        tests_run++; if (out_redirect_pc !== 32'h8000_0014) begin tests_failed++; $display("[TB] FAIL mret_redir_pc: got %h expected 80000014", out_redirect_pc); end
        release_resp();
    endtask

    task automatic test_illegal();
        model_addr = 12'h300;
        model_val  = 32'h0000_00AA;
        issue(3'b100, 1'b0, 1'b0, 12'h300, 5'd4, 32'h1234, 5'd7, 32'h0);
        step();
        tests_run++; if (csr_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ill_valid: got %b expected 1", csr_valid); end
        tests_run++; if (csr_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_wen: got %b expected 0", csr_wen); end
        step();
        tests_run++; if (out_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL ill_flag: got %b expected 1", out_illegal); end
        tests_run++; if (out_rd_wen !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_rd_wen: got %b expected 0", out_rd_wen); end
        tests_run++; if (out_redirect !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_redirect: got %b expected 0", out_redirect); end
        release_resp();
        // ecall and mret together is also illegal and must not raise the ecall strobe
        issue(3'b001, 1'b1, 1'b1, 12'h300, 5'd0, 32'h0, 5'd1, 32'h4);
        step();
        tests_run++; if (csr_is_ecall !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill2_is_ecall: got %b expected 0", csr_is_ecall); end
        step();
        tests_run++; if (out_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL ill2_flag: got %b expected 1", out_illegal); end
        release_resp();
    endtask

    task automatic test_stall();
        model_addr = 12'h300;
        model_val  = 32'h0000_00F0;
        issue(3'b010, 1'b0, 1'b0, 12'h300, 5'd2, 32'h0000_000F, 5'd9, 32'h0);
        step();
        tests_run++; if (csr_wdata !== 32'hFF) begin tests_failed++; $display("[TB] FAIL stall_rs_wdata: got %h expected 000000ff", csr_wdata); end
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++; if (out_valid !== 1'b1 || out_rd_data !== 32'hF0 || out_rd !== 5'd9) begin tests_failed++; $display("[TB] FAIL stall_hold%0d: got v=%b d=%h rd=%0d expected v=1 d=000000f0 rd=9", i, out_valid, out_rd_data, out_rd); end
            tests_run++; if (in_ready !== 1'b0 || csr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_busy%0d: got rdy=%b cv=%b expected 0 0", i, in_ready, csr_valid); end
        end
        in_valid = 1'b0;
        release_resp();
    endtask

    task automatic test_back_to_back();
        model_addr = 12'h340;
        model_val  = 32'h5555_0000;
        issue(3'b101, 1'b0, 1'b0, 12'h340, 5'd31, 32'hFFFF_FFFF, 5'd1, 32'h0);
        step();
        tests_run++; if (csr_wdata !== 32'h1F) begin tests_failed++; $display("[TB] FAIL b2b_rwi_wdata: got %h expected 0000001f", csr_wdata); end
        step();
        release_resp();
        model_val = 32'h0000_00FF;
        issue(3'b011, 1'b0, 1'b0, 12'h340, 5'd6, 32'h0000_000F, 5'd2, 32'h0);
        step();
        tests_run++; if (csr_wdata !== 32'hF0) begin tests_failed++; $display("[TB] FAIL b2b_rc_wdata: got %h expected 000000f0", csr_wdata); end
        step();
        tests_run++; if (out_rd_data !== 32'hFF) begin tests_failed++; $display("[TB] FAIL b2b_rc_rd_data: got %h expected 000000ff", out_rd_data); end
        release_resp();
    endtask

    task automatic test_reset_mid();
        int seen;
        model_addr = 12'h300;
        model_val  = 32'h1;
        // abort in READ: no write strobe may follow
        issue(3'b001, 1'b0, 1'b0, 12'h300, 5'd1, 32'h77, 5'd1, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (csr_valid !== 1'b0 || out_valid !== 1'b0) seen++;
            step();
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL rst_read_strobes: got %0d expected 0", seen); end
        // abort in WRITE: everything clears at once and stays quiet
        issue(3'b001, 1'b0, 1'b0, 12'h300, 5'd1, 32'h77, 5'd1, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (csr_valid !== 1'b0 || csr_wen !== 1'b0 || csr_wdata !== 32'h0 || csr_waddr !== 12'h0) begin tests_failed++; $display("[TB] FAIL rst_write_csr: got v=%b w=%b d=%h a=%h expected all 0", csr_valid, csr_wen, csr_wdata, csr_waddr); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_write_ready: got %b expected 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (csr_valid !== 1'b0 || out_valid !== 1'b0 || out_rd_data !== 32'h0) seen++;
            step();
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL rst_write_strobes: got %0d expected 0", seen); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_funct3    = '0;
        in_is_ecall  = 1'b0;
        in_is_mret   = 1'b0;
        in_csr_addr  = '0;
        in_rs1_idx   = '0;
        in_rs1_data  = '0;
        in_rd        = '0;
        in_pc        = '0;
        out_ready    = 1'b0;
        model_addr   = '0;
        model_val    = '0;
        test_reset();
        test_csrrw();
        test_csrrs_zero();
        test_csrrci();
        test_ecall();
        test_mret();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
